mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the RV32I core pipeline. It sits between execute and the `WriteBack` stage and holds the EX/MEM → MEM/WB pipeline register. It issues loads and stores to data memory over a request/grant/response handshake, stalls execute while an access is outstanding, and aligns and sign-extends load data. Each retired instruction is presented to write-back as a single-cycle bundle.

## Interface
- `XLEN`, 32, datapath and address width
- `MSB_REG_FILE`, 5, register-index width
- `MEM_WORD_WIDTH`, 32, data-memory word width; `MEM_WORD_WIDTH/8` byte enables

Ports:
- `clk`  in  1  core clock; all state updates on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `ex_valid`  in  1  EX/MEM bundle valid
- `ex_ready`  out  1  stage accepts a bundle this cycle
- `alu_result`  in  XLEN  ALU result / effective address
- `store_data`  in  XLEN  rs2 value for stores
- `pc_pls4`  in  XLEN  PC+4
- `rd`  in  MSB_REG_FILE  destination register
- `ctrl_mem_op`  in  e_mem_op  MEM_NONE / MEM_LOAD / MEM_STORE
- `ctrl_mem_size`  in  e_mem_size  BYTE, HALF, WORD, BYTE_U, HALF_U
- `ctrl_reg_wr`  in  1  register write-enable
- `ctrl_wb_to_rf_sel_in`  in  e_regfile_wb_sel  write-back source select
- `dmem_req`  out  1  memory request
- `dmem_we`  out  1  1 = store
- `dmem_addr`  out  XLEN  word-aligned address, bits [1:0] = 0
- `dmem_wdata`  out  MEM_WORD_WIDTH  lane-aligned store data
- `dmem_be`  out  MEM_WORD_WIDTH/8  byte enables
- `dmem_gnt`  in  1  request accepted
- `dmem_rvalid`  in  1  load data valid
- `dmem_rdata`  in  MEM_WORD_WIDTH  load word
- `AluData`, `pc_pls4_out`  out  XLEN  registered to write-back
- `dmem_load_data`  out  MEM_WORD_WIDTH  aligned, extended load value
- `rdOut`  out  MSB_REG_FILE  registered rd
- `ctrl_reg_wr_out`  out  1  write-enable pulse
- `ctrl_wb_to_rf_sel_out`  out  e_regfile_wb_sel  registered select
- `misaligned_err`  out  1  one-cycle misaligned-access pulse

## Operation
- **FSM states:** IDLE, REQ, WAIT.
- **Acceptance:** `ex_ready` = (state == IDLE). A bundle is accepted when `ex_valid && ex_ready`.
- **MEM_NONE:** stays in IDLE. The output register loads the bundle with `ctrl_reg_wr_out = ctrl_reg_wr`.
- **Aligned load or store:** captures address, data, size and control, then moves IDLE → REQ.
- **REQ:** `dmem_req` = 1 with stable address, data, `we` and `be` until `dmem_gnt`.
  - Store: on grant → IDLE. Retire with `ctrl_reg_wr_out` = 0.
  - Load: on grant → WAIT.
- **WAIT:** on `dmem_rvalid` → IDLE. Retire with the extracted data.
- **Misaligned access:** HALF with addr[0] = 1, or WORD with addr[1:0] ≠ 0. No memory request is issued. `misaligned_err` pulses, `ctrl_reg_wr_out` = 0, and the FSM stays in IDLE.
- **Store lanes:**
  - Offset `off` = addr[1:0].
  - SB: byte replicated ×4, `be` = 0001 << off.
  - SH: half replicated ×2, `be` = 0011 << off.
  - SW: `be` = 1111.
- **Load extract:**
  - BYTE / BYTE_U: `rdata[8*off +: 8]`, sign- or zero-extended.
  - HALF / HALF_U: `rdata[8*off +: 16]`, sign- or zero-extended.
  - WORD: the full `rdata` word.
- **Spurious response:** `dmem_rvalid` in IDLE or REQ is ignored.

## Timing
- **Reset values:** all outputs 0, state IDLE, `ex_ready` = 1. `ctrl_wb_to_rf_sel_out` resets to WB_ALU_OUT.
- **MEM_NONE:** accepted at cycle N, write-back outputs valid at N+1 for exactly one cycle.
- **Load:**
  - Accepted at N, `dmem_req` high from N+1.
  - Grant at G ≥ N+1.
  - rvalid at R ≥ G+1.
  - Outputs valid at R+1.
  - `ex_ready` returns high at R+1.
- **Store:** outputs (with write disabled) at G+1, `ex_ready` high at G+1.
- **Bubbles:** `ctrl_reg_wr_out` and `misaligned_err` are one-cycle pulses. They are 0 in every cycle with no retirement.
- **Reset mid-access:** the FSM returns to IDLE immediately and `dmem_req` drops. A later rvalid is discarded.

## Structure
- `memory_pkg` holds:
  - `e_mem_op` and `e_mem_size` (3-bit, encoded to match funct3)
  - `BE_WIDTH`
  - functions `f_store_align` and `f_load_extract`
- `e_regfile_wb_sel` is reused from `control_pkg`.
- One sub-module, `load_align`: combinational extract and extend from (`rdata`, `off`, `size`).

## Test plan
- ADD bundle, `alu_result` = 0x0000_1234, rd = 5 → next cycle `AluData` = 0x1234, `rdOut` = 5, one-cycle write pulse.
- LB at addr 0x103, rdata 0x80AA_BBCC, gnt after 2 cycles, rvalid 3 cycles later → `dmem_addr` = 0x100, load data 0xFFFF_FF80, `ex_ready` low for 6 cycles.
- SH at 0x202, `store_data` 0x0000_BEEF → wdata 0xBEEF_BEEF, `be` = 1100, `dmem_we` = 1, `ctrl_reg_wr_out` = 0.
- LW at 0x101 → no `dmem_req`, `misaligned_err` one-cycle pulse, no write.
- LHU at 0x002, rdata 0x8001_0000 → 0x0000_8001. A spurious rvalid during REQ is ignored.
- `rst` asserted in WAIT, late rvalid after release → all outputs stay 0, `ex_ready` = 1, no write.

Source files
------------

// File: rtl/control_pkg.sv
// Control-path types shared across pipeline stages.
package control_pkg;

    // Source of the value written back to the register file.
    typedef enum logic [1:0] {
        WB_ALU_OUT = 2'b00,
        WB_MEM     = 2'b01,
        WB_PC4     = 2'b10
    } e_regfile_wb_sel;

endpackage

// File: rtl/memory_pkg.sv
// Data-memory access types and store/load lane helpers for the MEM stage.
package memory_pkg;

    localparam int unsigned MEM_W    = 32;
    localparam int unsigned BE_WIDTH = MEM_W / 8;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10
    } e_mem_op;

    // Encoded to match the funct3 field of loads/stores.
    typedef enum logic [2:0] {
        BYTE   = 3'b000,
        HALF   = 3'b001,
        WORD   = 3'b010,
        BYTE_U = 3'b100,
        HALF_U = 3'b101
    } e_mem_size;

    typedef struct packed {
        logic [BE_WIDTH-1:0] be;
        logic [MEM_W-1:0]    wdata;
    } t_store_lanes;

    // Replicates store data across lanes and selects the byte enables.
    function automatic t_store_lanes f_store_align(input logic [MEM_W-1:0] data,
                                                   input logic [1:0]       off,
                                                   input e_mem_size        size);
        t_store_lanes l;
        case (size)
            BYTE, BYTE_U: begin
                l.wdata = {4{data[7:0]}};
                l.be    = 4'b0001 << off;
            end
            HALF, HALF_U: begin
                l.wdata = {2{data[15:0]}};
                l.be    = 4'b0011 << off;
            end
            default: begin
                l.wdata = data;
                l.be    = '1;
            end
        endcase
        return l;
    endfunction

    // Picks the addressed byte/half out of the read word and extends it.
    function automatic logic [MEM_W-1:0] f_load_extract(input logic [MEM_W-1:0] rdata,
                                                        input logic [1:0]       off,
                                                        input e_mem_size        size);
        logic [7:0]  b;
        logic [15:0] h;
        logic [MEM_W-1:0] res;
        b = 8'(rdata >> {off, 3'b000});
        h = 16'(rdata >> {off, 3'b000});
        case (size)
            BYTE:    res = {{24{b[7]}}, b};
            BYTE_U:  res = {24'b0, b};
            HALF:    res = {{16{h[15]}}, h};
            HALF_U:  res = {16'b0, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // HALF needs even addresses, WORD needs word-aligned addresses.
    function automatic logic f_misaligned(input logic [1:0] off,
                                          input e_mem_size  size);
        logic m;
        case (size)
            HALF, HALF_U: m = off[0];
            WORD:         m = (off != 2'b00);
            default:      m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational alignment and sign/zero extension of a loaded word.
module load_align
    import memory_pkg::*;
(
    input  logic [MEM_W-1:0] rdata,
    input  logic [1:0]       off,
    input  e_mem_size        size,
    output logic [MEM_W-1:0] data
);

    // Extract the addressed lane and extend it to a full word.
    always_comb begin
        data = f_load_extract(rdata, off, size);
    end

endmodule

// File: rtl/mem_access.sv
// RV32I memory-access stage: EX/MEM capture, data-memory handshake,
// load alignment and the MEM/WB output register.
module mem_access
    import memory_pkg::*, control_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned MSB_REG_FILE   = 5,
    parameter int unsigned MEM_WORD_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ex_valid,
    output logic                        ex_ready,
    input  logic [XLEN-1:0]             alu_result,
    input  logic [XLEN-1:0]             store_data,
    input  logic [XLEN-1:0]             pc_pls4,
    input  logic [MSB_REG_FILE-1:0]     rd,
    input  e_mem_op                     ctrl_mem_op,
    input  e_mem_size                   ctrl_mem_size,
    input  logic                        ctrl_reg_wr,
    input  e_regfile_wb_sel             ctrl_wb_to_rf_sel_in,
    output logic                        dmem_req,
    output logic                        dmem_we,
    output logic [XLEN-1:0]             dmem_addr,
    output logic [MEM_WORD_WIDTH-1:0]   dmem_wdata,
    output logic [MEM_WORD_WIDTH/8-1:0] dmem_be,
    input  logic                        dmem_gnt,
    input  logic                        dmem_rvalid,
    input  logic [MEM_WORD_WIDTH-1:0]   dmem_rdata,
    output logic [XLEN-1:0]             AluData,
    output logic [XLEN-1:0]             pc_pls4_out,
    output logic [MEM_WORD_WIDTH-1:0]   dmem_load_data,
    output logic [MSB_REG_FILE-1:0]     rdOut,
    output logic                        ctrl_reg_wr_out,
    output e_regfile_wb_sel             ctrl_wb_to_rf_sel_out,
    output logic                        misaligned_err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } e_state;

    e_state                    state;
    logic [XLEN-1:0]           alu_q;
    logic [XLEN-1:0]           pc4_q;
    logic [MSB_REG_FILE-1:0]   rd_q;
    logic                      wr_q;
    e_regfile_wb_sel           sel_q;
    e_mem_size                 size_q;

    t_store_lanes              lanes;
    logic                      mis;
    logic                      is_mem;
    logic [MEM_WORD_WIDTH-1:0] load_value;

    assign ex_ready = (state == IDLE);

    // Decode the incoming bundle: lane placement, alignment and access kind.
    always_comb begin
        lanes  = f_store_align(store_data, alu_result[1:0], ctrl_mem_size);
        mis    = f_misaligned(alu_result[1:0], ctrl_mem_size);
        is_mem = (ctrl_mem_op == MEM_LOAD) || (ctrl_mem_op == MEM_STORE);
    end

    load_align u_load_align (
        .rdata (dmem_rdata),
        .off   (alu_q[1:0]),
        .size  (size_q),
        .data  (load_value)
    );

    // Access FSM plus the registered memory-request and write-back outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= IDLE;
            alu_q                 <= '0;
            pc4_q                 <= '0;
            rd_q                  <= '0;
            wr_q                  <= 1'b0;
            sel_q                 <= WB_ALU_OUT;
            size_q                <= BYTE;
            dmem_req              <= 1'b0;
            dmem_we               <= 1'b0;
            dmem_addr             <= '0;
            dmem_wdata            <= '0;
            dmem_be               <= '0;
            AluData               <= '0;
            pc_pls4_out           <= '0;
            dmem_load_data        <= '0;
            rdOut                 <= '0;
            ctrl_reg_wr_out       <= 1'b0;
            ctrl_wb_to_rf_sel_out <= WB_ALU_OUT;
            misaligned_err        <= 1'b0;
        end else begin
            ctrl_reg_wr_out <= 1'b0;
            misaligned_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (is_mem && !mis) begin
                            alu_q      <= alu_result;
                            pc4_q      <= pc_pls4;
                            rd_q       <= rd;
                            wr_q       <= ctrl_reg_wr;
                            sel_q      <= ctrl_wb_to_rf_sel_in;
                            size_q     <= ctrl_mem_size;
                            dmem_req   <= 1'b1;
                            dmem_we    <= (ctrl_mem_op == MEM_STORE);
                            dmem_addr  <= {alu_result[XLEN-1:2], 2'b00};
                            dmem_wdata <= (ctrl_mem_op == MEM_STORE) ? lanes.wdata : '0;
                            dmem_be    <= lanes.be;
                            state      <= REQ;
                        end else begin
                            // Non-memory and misaligned bundles retire straight from IDLE.
                            AluData               <= alu_result;
                            pc_pls4_out           <= pc_pls4;
                            rdOut                 <= rd;
                            ctrl_wb_to_rf_sel_out <= ctrl_wb_to_rf_sel_in;
                            ctrl_reg_wr_out       <= ctrl_reg_wr && !is_mem;
                            misaligned_err        <= is_mem;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        if (dmem_we) begin
                            AluData               <= alu_q;
                            pc_pls4_out           <= pc4_q;
                            rdOut                 <= rd_q;
                            ctrl_wb_to_rf_sel_out <= sel_q;
                            state                 <= IDLE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        AluData               <= alu_q;
                        pc_pls4_out           <= pc4_q;
                        rdOut                 <= rd_q;
                        ctrl_wb_to_rf_sel_out <= sel_q;
                        dmem_load_data        <= load_value;
                        ctrl_reg_wr_out       <= wr_q;
                        state                 <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed bundles, a scripted memory
// responder, and a monitor checking write-back and memory requests.
module tb_mem_access;
    import memory_pkg::*;
    import control_pkg::*;

    logic            clk;
    logic            rst;
    logic            ex_valid;
    logic            ex_ready;
    logic [31:0]     alu_result;
    logic [31:0]     store_data;
    logic [31:0]     pc_pls4;
    logic [4:0]      rd;
    e_mem_op         ctrl_mem_op;
    e_mem_size       ctrl_mem_size;
    logic            ctrl_reg_wr;
    e_regfile_wb_sel ctrl_wb_to_rf_sel_in;
    logic            dmem_req;
    logic            dmem_we;
    logic [31:0]     dmem_addr;
    logic [31:0]     dmem_wdata;
    logic [3:0]      dmem_be;
    logic            dmem_gnt;
    logic            dmem_rvalid;
    logic [31:0]     dmem_rdata;
    logic [31:0]     AluData;
    logic [31:0]     pc_pls4_out;
    logic [31:0]     dmem_load_data;
    logic [4:0]      rdOut;
    logic            ctrl_reg_wr_out;
    e_regfile_wb_sel ctrl_wb_to_rf_sel_out;
    logic            misaligned_err;

    mem_access #(
        .XLEN           (32),
        .MSB_REG_FILE   (5),
        .MEM_WORD_WIDTH (32)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .ex_valid              (ex_valid),
        .ex_ready              (ex_ready),
        .alu_result            (alu_result),
        .store_data            (store_data),
        .pc_pls4               (pc_pls4),
        .rd                    (rd),
        .ctrl_mem_op           (ctrl_mem_op),
        .ctrl_mem_size         (ctrl_mem_size),
        .ctrl_reg_wr           (ctrl_reg_wr),
        .ctrl_wb_to_rf_sel_in  (ctrl_wb_to_rf_sel_in),
        .dmem_req              (dmem_req),
        .dmem_we               (dmem_we),
        .dmem_addr             (dmem_addr),
        .dmem_wdata            (dmem_wdata),
        .dmem_be               (dmem_be),
        .dmem_gnt              (dmem_gnt),
        .dmem_rvalid           (dmem_rvalid),
        .dmem_rdata            (dmem_rdata),
        .AluData               (AluData),
        .pc_pls4_out           (pc_pls4_out),
        .dmem_load_data        (dmem_load_data),
        .rdOut                 (rdOut),
        .ctrl_reg_wr_out       (ctrl_reg_wr_out),
        .ctrl_wb_to_rf_sel_out (ctrl_wb_to_rf_sel_out),
        .misaligned_err        (misaligned_err)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] ld;
        logic [4:0]  rd;
        logic        wr;
        logic [1:0]  sel;
        logic        mis;
        bit          chk_ld;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_exp_t;

    wb_exp_t  wb_q[$];
    req_exp_t req_q[$];
    wb_exp_t  mw;
    req_exp_t mr;

    int checks = 0;
    int errors = 0;
    int low_cnt = 0;
    int low0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_wb(input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] ld,
                           input logic [4:0] r, input logic wr, input e_regfile_wb_sel sel,
                           input logic mis, input bit chk_ld);
        wb_exp_t e;
        e.alu = alu; e.pc4 = pc4; e.ld = ld; e.rd = r; e.wr = wr;
        e.sel = sel; e.mis = mis; e.chk_ld = chk_ld;
        wb_q.push_back(e);
    endtask

    task automatic push_req(input logic [31:0] addr, input logic we, input logic [3:0] be,
                            input logic [31:0] wdata);
        req_exp_t e;
        e.addr = addr; e.we = we; e.be = be; e.wdata = wdata;
        req_q.push_back(e);
    endtask

    // Present one bundle; returns at +1 after the accepting edge.
    task automatic issue(input e_mem_op op, input e_mem_size sz, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [31:0] pc4, input logic [4:0] r,
                         input logic wr, input e_regfile_wb_sel sel);
        int n = 0;
        while (!ex_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ex_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_ready_timeout: ex_ready still 0 after %0d cycles", n);
        end
        ctrl_mem_op          = op;
        ctrl_mem_size        = sz;
        alu_result           = alu;
        store_data           = sd;
        pc_pls4              = pc4;
        rd                   = r;
        ctrl_reg_wr          = wr;
        ctrl_wb_to_rf_sel_in = sel;
        ex_valid             = 1'b1;
        @(posedge clk); #1;
        ex_valid             = 1'b0;
        ctrl_mem_op          = MEM_NONE;
    endtask

    // Scripted memory: grant after gdly cycles, data rdly cycles after the grant.
    task automatic serve(input int gdly, input bit is_load, input int rdly,
                         input logic [31:0] rdata, input bit spur);
        for (int i = 0; i < gdly; i++) begin
            if (spur && i == 0) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = 32'hFFFF_FFFF;
            end
            @(posedge clk); #1;
            dmem_rvalid = 1'b0;
            dmem_rdata  = '0;
        end
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        if (is_load) begin
            for (int i = 1; i < rdly; i++) begin
                @(posedge clk); #1;
            end
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdata;
            @(posedge clk); #1;
            dmem_rvalid = 1'b0;
            dmem_rdata  = '0;
        end
    endtask

    always @(negedge clk) begin
        if (!ex_ready) low_cnt++;
    end

    // Monitor: compare every retirement and every granted request with the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (ctrl_reg_wr_out || misaligned_err) begin
                if (wb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: wr=%0b mis=%0b with nothing expected at %0t",
                             ctrl_reg_wr_out, misaligned_err, $time);
                end else begin
                    mw = wb_q.pop_front();
                    chk("wb_alu", AluData, mw.alu);
                    chk("wb_pc4", pc_pls4_out, mw.pc4);
                    chk("wb_rd", 32'(rdOut), 32'(mw.rd));
                    chk("wb_wr", 32'(ctrl_reg_wr_out), 32'(mw.wr));
                    chk("wb_mis", 32'(misaligned_err), 32'(mw.mis));
                    chk("wb_sel", 32'(ctrl_wb_to_rf_sel_out), 32'(mw.sel));
                    if (mw.chk_ld) chk("wb_load_data", dmem_load_data, mw.ld);
                end
            end
            if (dmem_req && req_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL req_unexpected: dmem_req=1 addr=0x%08h with nothing expected at %0t",
                         dmem_addr, $time);
            end
            if (dmem_req && dmem_gnt && req_q.size() != 0) begin
                mr = req_q.pop_front();
                chk("req_addr", dmem_addr, mr.addr);
                chk("req_we", 32'(dmem_we), 32'(mr.we));
                chk("req_be", 32'(dmem_be), 32'(mr.be));
                if (mr.we) chk("req_wdata", dmem_wdata, mr.wdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                  = 1'b1;
        ex_valid             = 1'b0;
        alu_result           = '0;
        store_data           = '0;
        pc_pls4              = '0;
        rd                   = '0;
        ctrl_mem_op          = MEM_NONE;
        ctrl_mem_size        = WORD;
        ctrl_reg_wr          = 1'b0;
        ctrl_wb_to_rf_sel_in = WB_ALU_OUT;
        dmem_gnt             = 1'b0;
        dmem_rvalid          = 1'b0;
        dmem_rdata           = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_alu", AluData, 32'd0);
        chk("rst_wr", 32'(ctrl_reg_wr_out), 32'd0);
        chk("rst_sel", 32'(ctrl_wb_to_rf_sel_out), 32'(WB_ALU_OUT));
        rst = 1'b0;
        @(posedge clk); #1;

        // ADD: single-cycle write-back bundle
        push_wb(32'h0000_1234, 32'h0000_0104, 32'h0, 5'd5, 1'b1, WB_ALU_OUT, 1'b0, 1'b0);
        issue(MEM_NONE, WORD, 32'h0000_1234, 32'h0, 32'h0000_0104, 5'd5, 1'b1, WB_ALU_OUT);
        chk("add_wr_pulse", 32'(ctrl_reg_wr_out), 32'd1);
        chk("add_rd", 32'(rdOut), 32'd5);
        @(posedge clk); #1;
        chk("add_wr_drop", 32'(ctrl_reg_wr_out), 32'd0);

        // LB at 0x103, grant after 2 cycles, rvalid 3 cycles after grant
        low0 = low_cnt;
        push_req(32'h0000_0100, 1'b0, 4'b1000, 32'h0);
        push_wb(32'h0000_0103, 32'h0000_0108, 32'hFFFF_FF80, 5'd7, 1'b1, WB_MEM, 1'b0, 1'b1);
        issue(MEM_LOAD, BYTE, 32'h0000_0103, 32'hAAAA_AAAA, 32'h0000_0108, 5'd7, 1'b1, WB_MEM);
        chk("lb_req_high", 32'(dmem_req), 32'd1);
        chk("lb_addr", dmem_addr, 32'h0000_0100);
        serve(2, 1'b1, 3, 32'h80AA_BBCC, 1'b0);
        chk("lb_ready_back", 32'(ex_ready), 32'd1);
        chk("lb_load_data", dmem_load_data, 32'hFFFF_FF80);
        chk("lb_ready_low_cycles", 32'(low_cnt - low0), 32'd6);

        // SH at 0x202
        push_req(32'h0000_0200, 1'b1, 4'b1100, 32'hBEEF_BEEF);
        issue(MEM_STORE, HALF, 32'h0000_0202, 32'h0000_BEEF, 32'h0000_010C, 5'd3, 1'b1, WB_ALU_OUT);
        chk("sh_we", 32'(dmem_we), 32'd1);
        chk("sh_be", 32'(dmem_be), 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        serve(1, 1'b0, 0, 32'h0, 1'b0);
        chk("sh_no_write", 32'(ctrl_reg_wr_out), 32'd0);
        chk("sh_ready_back", 32'(ex_ready), 32'd1);

        // SB at 0x001 and SW at 0x040
        push_req(32'h0000_0000, 1'b1, 4'b0010, 32'h7878_7878);
        issue(MEM_STORE, BYTE, 32'h0000_0001, 32'h1234_5678, 32'h0000_0110, 5'd0, 1'b0, WB_ALU_OUT);
        serve(0, 1'b0, 0, 32'h0, 1'b0);
        push_req(32'h0000_0040, 1'b1, 4'b1111, 32'hCAFE_F00D);
        issue(MEM_STORE, WORD, 32'h0000_0040, 32'hCAFE_F00D, 32'h0000_0114, 5'd0, 1'b0, WB_ALU_OUT);
        serve(0, 1'b0, 0, 32'h0, 1'b0);

        // LW at 0x101: misaligned, no request
        push_wb(32'h0000_0101, 32'h0000_0118, 32'h0, 5'd9, 1'b0, WB_MEM, 1'b1, 1'b0);
        issue(MEM_LOAD, WORD, 32'h0000_0101, 32'h0, 32'h0000_0118, 5'd9, 1'b1, WB_MEM);
        chk("lw_mis_pulse", 32'(misaligned_err), 32'd1);
        chk("lw_no_req", 32'(dmem_req), 32'd0);
        chk("lw_ready", 32'(ex_ready), 32'd1);
        @(posedge clk); #1;
        chk("lw_mis_drop", 32'(misaligned_err), 32'd0);
        chk("lw_no_req_later", 32'(dmem_req), 32'd0);

        // SH at 0x203: misaligned store
        push_wb(32'h0000_0203, 32'h0000_011C, 32'h0, 5'd0, 1'b0, WB_ALU_OUT, 1'b1, 1'b0);
        issue(MEM_STORE, HALF, 32'h0000_0203, 32'h0000_1111, 32'h0000_011C, 5'd0, 1'b0, WB_ALU_OUT);
        @(posedge clk); #1;

        // LHU at 0x002 with a spurious rvalid during REQ
        push_req(32'h0000_0000, 1'b0, 4'b1100, 32'h0);
        push_wb(32'h0000_0002, 32'h0000_0120, 32'h0000_8001, 5'd11, 1'b1, WB_MEM, 1'b0, 1'b1);
        issue(MEM_LOAD, HALF_U, 32'h0000_0002, 32'h0, 32'h0000_0120, 5'd11, 1'b1, WB_MEM);
        serve(2, 1'b1, 1, 32'h8001_0000, 1'b1);

        // LH at 0x000 and LBU at 0x001
        push_req(32'h0000_0000, 1'b0, 4'b0011, 32'h0);
        push_wb(32'h0000_0000, 32'h0000_0124, 32'hFFFF_8765, 5'd12, 1'b1, WB_MEM, 1'b0, 1'b1);
        issue(MEM_LOAD, HALF, 32'h0000_0000, 32'h0, 32'h0000_0124, 5'd12, 1'b1, WB_MEM);
        serve(0, 1'b1, 2, 32'h1234_8765, 1'b0);
        push_req(32'h0000_0000, 1'b0, 4'b0010, 32'h0);
        push_wb(32'h0000_0001, 32'h0000_0128, 32'h0000_00F1, 5'd13, 1'b1, WB_MEM, 1'b0, 1'b1);
        issue(MEM_LOAD, BYTE_U, 32'h0000_0001, 32'h0, 32'h0000_0128, 5'd13, 1'b1, WB_MEM);
        serve(1, 1'b1, 1, 32'h0000_F100, 1'b0);

        // JAL-style bundle selecting PC+4
        push_wb(32'h0000_2000, 32'h0000_2004, 32'h0, 5'd1, 1'b1, WB_PC4, 1'b0, 1'b0);
        issue(MEM_NONE, WORD, 32'h0000_2000, 32'h0, 32'h0000_2004, 5'd1, 1'b1, WB_PC4);
        @(posedge clk); #1;

        // Reset while waiting for load data, then a late rvalid
        push_req(32'h0000_0300, 1'b0, 4'b1111, 32'h0);
        issue(MEM_LOAD, WORD, 32'h0000_0300, 32'h0, 32'h0000_0304, 5'd3, 1'b1, WB_MEM);
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        chk("wait_ready_low", 32'(ex_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_req_drop", 32'(dmem_req), 32'd0);
        chk("midrst_ready", 32'(ex_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5555_5555;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        chk("late_alu", AluData, 32'd0);
        chk("late_load_data", dmem_load_data, 32'd0);
        chk("late_rd", 32'(rdOut), 32'd0);
        chk("late_pc4", pc_pls4_out, 32'd0);
        chk("late_wr", 32'(ctrl_reg_wr_out), 32'd0);
        chk("late_sel", 32'(ctrl_wb_to_rf_sel_out), 32'(WB_ALU_OUT));
        chk("late_ready", 32'(ex_ready), 32'd1);
        chk("late_req", 32'(dmem_req), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        chk("req_queue_drained", 32'(req_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
